ex_alu_stage: RTL

Registered execute-stage ALU for the 64-bit pipelined ARM core. It takes forwarded operands from ID/EX and selects among the bitwise AND/OR/XOR results, add, subtract and pass-B. It computes NZCV flags, then captures the result and destination metadata into the EX/MEM pipeline register. It also owns the architectural flags register used by B.cond, with a same-cycle forwarding path.

---
 rtl/ex_alu_if.sv | 33 +++
 rtl/ex_alu_stage.sv | 111 +++++++++++
 2 files changed

// File: rtl/ex_alu_if.sv
// ID/EX -> EX/MEM handshake bundle for the execute-stage ALU.
// The master drives the instruction slot; the slave is the ALU stage.
interface ex_alu_if #(
  parameter int N = 64
);
  logic         in_valid;
  logic         stall;
  logic         flush;
  logic [2:0]   alu_op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         set_flags;
  logic [4:0]   rd_in;
  logic         reg_write_in;

  logic         out_valid;
  logic [N-1:0] result;
  logic [4:0]   rd_out;
  logic         reg_write_out;
  logic         result_zero;
  logic [3:0]   flags;
  logic [3:0]   flags_fwd;

  modport master (
    output in_valid, stall, flush, alu_op, A, B, set_flags, rd_in, reg_write_in,
    input  out_valid, result, rd_out, reg_write_out, result_zero, flags, flags_fwd
  );

  modport slave (
    input  in_valid, stall, flush, alu_op, A, B, set_flags, rd_in, reg_write_in,
    output out_valid, result, rd_out, reg_write_out, result_zero, flags, flags_fwd
  );
endinterface

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with EX/MEM pipeline register and the architectural NZCV
// register, including a same-cycle forward of freshly computed flags.
module ex_alu_stage #(
  parameter int N = 64
) (
  input  logic   clk,
  input  logic   reset,
  ex_alu_if.slave bus
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;

  // Returns {C, V, r}; logic ops, pass-B and reserved encodings clear C and V.
  function automatic logic [N+1:0] alu_eval(input logic [2:0]   op,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b);
    logic [N:0]   sum;
    logic [N-1:0] r;
    logic         c;
    logic         v;
    sum = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_PASS: r = b;
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[N-1:0];
        c   = sum[N];
        v   = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      OP_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        r   = sum[N-1:0];
        c   = sum[N];
        v   = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  function automatic logic [3:0] nzcv_of(input logic [N+1:0] ev);
    return {ev[N-1], (ev[N-1:0] == '0), ev[N+1], ev[N]};
  endfunction

  logic signed [N-1:0] r_p0;
  logic [N+1:0]        eval_p0;
  logic [3:0]          nzcv_p0;
  logic                fw_p0;

  logic                vld_p1;
  logic signed [N-1:0] result_p1;
  logic [4:0]          rd_p1;
  logic                wr_p1;
  logic                zero_p1;
  logic [3:0]          flags_q;

  always_comb begin
    eval_p0 = alu_eval(bus.alu_op, bus.A, bus.B);
    r_p0    = eval_p0[N-1:0];
    nzcv_p0 = nzcv_of(eval_p0);
    fw_p0   = bus.in_valid && bus.set_flags && !bus.stall && !bus.flush;
  end

  // p0 -> p1: EX/MEM register; flush clears control even while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      wr_p1     <= 1'b0;
      result_p1 <= '0;
      rd_p1     <= '0;
      zero_p1   <= 1'b1;
      flags_q   <= 4'b0000;
    end else begin
      if (bus.flush) begin
        vld_p1 <= 1'b0;
        wr_p1  <= 1'b0;
      end else if (!bus.stall) begin
        vld_p1 <= bus.in_valid;
        wr_p1  <= bus.reg_write_in && bus.in_valid;
      end
      if (!bus.stall) begin
        result_p1 <= r_p0;
        rd_p1     <= bus.rd_in;
        zero_p1   <= (r_p0 == '0);
      end
      if (fw_p0) begin
        flags_q <= nzcv_p0;
      end
    end
  end

  assign bus.out_valid     = vld_p1;
  assign bus.result        = result_p1;
  assign bus.rd_out        = rd_p1;
  assign bus.reg_write_out = wr_p1;
  assign bus.result_zero   = zero_p1;
  assign bus.flags         = flags_q;
  assign bus.flags_fwd     = fw_p0 ? nzcv_p0 : flags_q;

endmodule
